// File: rtl/stack_pkg.sv
// Shared definitions for the stack command controller and its ALU.
//   DBITS_DEF / DEPTH_DEF : defaults shared with reg_file
//   OP_*                  : 3-bit command opcodes
//   state_t               : controller FSM states
package stack_pkg;

  localparam int unsigned DBITS_DEF = 32;
  localparam int unsigned DEPTH_DEF = 16;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_AND   = 3'd5;
  localparam logic [2:0] OP_OR    = 3'd6;
  localparam logic [2:0] OP_DROP2 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/stack_alu.sv
// Combinational binary-op unit for the stack controller.
//   op     : command opcode (only ADD/SUB/AND/OR produce a value)
//   a      : second stack entry
//   b      : top of stack
//   result : a op b, modulo 2^DBITS; 0 for non-arithmetic opcodes
module stack_alu
  import stack_pkg::*;
#(
  parameter int unsigned DBITS = DBITS_DEF
) (
  input  logic [2:0]       op,
  input  logic [DBITS-1:0] a,
  input  logic [DBITS-1:0] b,
  output logic [DBITS-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/stack_cmd_ctrl.sv
// Command-side initiator for the stack register file.
// Accepts one command at a time (valid/ready), checks it against the tracked
// occupancy, drives the reg_file pop/pop/push strobes for one EXEC cycle and
// returns a registered response (valid/ready).
//   clk, rst           : clock, asynchronous active-low reset
//   cmd_valid/ready    : command handshake; cmd_op, cmd_imm command payload
//   rsp_valid/ready    : response handshake; rsp_data result, rsp_err reject
//   en1, en2, we, din  : reg_file pop-top, pop-second, push, push data
//   dout1, dout2       : reg_file top / second entry (combinational)
//   depth              : current stack occupancy
module stack_cmd_ctrl
  import stack_pkg::*;
#(
  parameter  int unsigned DBITS = DBITS_DEF,
  parameter  int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [DBITS-1:0] cmd_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DBITS-1:0] rsp_data,
  output logic             rsp_err,
  output logic             en1,
  output logic             en2,
  output logic             we,
  output logic [DBITS-1:0] din,
  input  logic [DBITS-1:0] dout1,
  input  logic [DBITS-1:0] dout2,
  output logic [DW-1:0]    depth
);

  state_t           state_q, state_d;
  logic             cmd_ready_q;
  logic [2:0]       op_q;
  logic [DBITS-1:0] imm_q;
  logic [DW-1:0]    depth_q;
  logic [DBITS-1:0] rsp_data_q;
  logic             rsp_err_q;

  logic [1:0]       pops;
  logic             push;
  logic [DW:0]      depth_calc;
  logic             underflow;
  logic             overflow;
  logic             legal;
  logic             exec_ok;
  logic             accept;
  logic [DBITS-1:0] alu_res;
  logic [DBITS-1:0] push_val;
  logic [DBITS-1:0] rsp_result;

  stack_alu #(
    .DBITS(DBITS)
  ) u_alu (
    .op    (op_q),
    .a     (dout2),
    .b     (dout1),
    .result(alu_res)
  );

  // Stack effect of the latched opcode.
  always_comb begin
    pops = 2'd0;
    push = 1'b0;
    case (op_q)
      OP_PUSH:                     push = 1'b1;
      OP_POP:                      pops = 2'd1;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        pops = 2'd2;
        push = 1'b1;
      end
      OP_DROP2:                    pops = 2'd2;
      default: begin
        pops = 2'd0;
        push = 1'b0;
      end
    endcase
  end

  // One extra bit keeps the post-op occupancy from wrapping before the
  // overflow compare; the value is only meaningful when no underflow.
  always_comb begin
    underflow  = {1'b0, depth_q} < (DW + 1)'(pops);
    depth_calc = {1'b0, depth_q} - (DW + 1)'(pops) + (DW + 1)'(push);
    overflow   = !underflow && (depth_calc > (DW + 1)'(DEPTH));
    legal      = !underflow && !overflow;
  end

  assign exec_ok = (state_q == ST_EXEC) && legal;
  assign accept  = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;

  always_comb begin
    push_val = (op_q == OP_PUSH) ? imm_q : alu_res;
    en1      = exec_ok && (pops != 2'd0);
    en2      = exec_ok && (pops == 2'd2);
    we       = exec_ok && push;
    din      = we ? push_val : '0;
  end

  always_comb begin
    rsp_result = '0;
    case (op_q)
      OP_PUSH:                       rsp_result = imm_q;
      OP_POP, OP_DROP2:              rsp_result = dout1;
      OP_ADD, OP_SUB, OP_AND, OP_OR: rsp_result = alu_res;
      default:                       rsp_result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_EXEC;
      ST_EXEC:                state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // cmd_ready is registered from the next state so it reads 0 while reset
  // is asserted and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      op_q        <= OP_NOP;
      imm_q       <= '0;
      depth_q     <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      if (accept) begin
        op_q  <= cmd_op;
        imm_q <= cmd_imm;
      end
      if (state_q == ST_EXEC) begin
        if (legal) begin
          depth_q    <= depth_calc[DW-1:0];
          rsp_data_q <= rsp_result;
          rsp_err_q  <= 1'b0;
        end else begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign depth     = depth_q;

endmodule

// File: tb/tb_stack_cmd_ctrl.sv
module tb_stack_cmd_ctrl;

  localparam int unsigned DBITS = 32;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic        en1;
    logic        en2;
    logic        we;
    logic [31:0] din;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  depth;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_imm = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        en1, en2, we;
  logic [31:0] din;
  logic [31:0] dout1, dout2;
  logic [4:0]  depth;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  stack_cmd_ctrl #(.DBITS(DBITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .en1(en1), .en2(en2), .we(we), .din(din),
    .dout1(dout1), .dout2(dout2), .depth(depth)
  );

  // Behavioural reg_file reacting to the DUT strobes.
  logic [31:0] mem [0:15];
  int unsigned sp;

  always @(posedge clk or negedge rst) begin
    if (!rst) sp <= 0;
    else begin
      int unsigned b;
      b = sp - (en1 ? 1 : 0) - (en2 ? 1 : 0);
      if (we) begin
        if (b < 16) mem[4'(b)] <= din;
        sp <= b + 1;
      end else sp <= b;
    end
  end

  assign dout1 = (sp >= 1 && sp <= 16) ? mem[4'(sp - 1)] : '0;
  assign dout2 = (sp >= 2 && sp <= 16) ? mem[4'(sp - 2)] : '0;

  // Reference stack: element size()-1 is top.
  logic [31:0] ref_q [$];

  function automatic txn_t ref_step(input logic [2:0] op, input logic [31:0] imm);
    txn_t e;
    int n, need, add;
    logic [31:0] top, sec, res, val;
    e = '0;
    n = ref_q.size();
    case (op)
      3'd1: begin need = 0; add = 1; end
      3'd2: begin need = 1; add = 0; end
      3'd3, 3'd4, 3'd5, 3'd6: begin need = 2; add = 1; end
      3'd7: begin need = 2; add = 0; end
      default: begin need = 0; add = 0; end
    endcase
    top = (n >= 1) ? ref_q[n-1] : '0;
    sec = (n >= 2) ? ref_q[n-2] : '0;
    case (op)
      3'd3: res = sec + top;
      3'd4: res = sec - top;
      3'd5: res = sec & top;
      3'd6: res = sec | top;
      default: res = '0;
    endcase
    if (n < need || n - need + add > int'(DEPTH)) begin
      e.rsp_err = 1'b1;
      e.depth   = 5'(n);
    end else begin
      val   = (op == 3'd1) ? imm : res;
      e.en1 = (need >= 1);
      e.en2 = (need == 2);
      e.we  = (add == 1);
      e.din = (add == 1) ? val : '0;
      if (op == 3'd1) e.rsp_data = imm;
      else if (op == 3'd2 || op == 3'd7) e.rsp_data = top;
      else if (op >= 3'd3 && op <= 3'd6) e.rsp_data = res;
      else e.rsp_data = '0;
      repeat (need) void'(ref_q.pop_back());
      if (add == 1) ref_q.push_back(val);
      e.depth = 5'(ref_q.size());
    end
    return e;
  endfunction

  // Runs one command with `hold` cycles of response backpressure and returns
  // what was observed; proto_ok collects handshake/stability observations.
  task automatic do_cmd(input logic [2:0] op, input logic [31:0] imm, input int unsigned hold,
                        output txn_t obs, output bit proto_ok, output bit timeout);
    int unsigned w;
    obs = '0; proto_ok = 1'b1; timeout = 1'b0; w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin @(negedge clk); w++; end
    if (!cmd_ready) begin timeout = 1'b1; return; end
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    @(negedge clk);
    cmd_valid = 1'b0;
    obs.en1 = en1; obs.en2 = en2; obs.we = we; obs.din = din;
    proto_ok &= (cmd_ready === 1'b0) && (rsp_valid === 1'b0);
    @(negedge clk);
    obs.rsp_err = rsp_err; obs.rsp_data = rsp_data; obs.depth = depth;
    proto_ok &= (rsp_valid === 1'b1) && ({en1, en2, we} === 3'b000) && (cmd_ready === 1'b0);
    repeat (hold) begin
      @(negedge clk);
      proto_ok &= (rsp_valid === 1'b1) && (rsp_data === obs.rsp_data) && (rsp_err === obs.rsp_err)
                  && (cmd_ready === 1'b0) && ({en1, en2, we} === 3'b000);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    proto_ok &= (rsp_valid === 1'b0) && (cmd_ready === 1'b1);
  endtask

  task automatic apply_reset(input int unsigned cycles);
    rst = 1'b0;
    ref_q.delete();
    repeat (cycles) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ref_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cmd_ready, rsp_valid, rsp_data, rsp_err, en1, en2, we, din, depth} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc%0d: got rdy=%b rv=%b data=%h err=%b en1=%b en2=%b we=%b din=%h depth=%0d, want all 0",
                 i, cmd_ready, rsp_valid, rsp_data, rsp_err, en1, en2, we, din, depth);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || depth !== 5'd0) begin
      n_bad++;
      $display("FAIL reset_release: got rdy=%b depth=%0d, want rdy=1 depth=0", cmd_ready, depth);
    end
  endtask

  task automatic run_and_check(input string name, input logic [2:0] op, input logic [31:0] imm,
                               input int unsigned hold);
    txn_t exp, obs;
    bit ok, to;
    exp = ref_step(op, imm);
    do_cmd(op, imm, hold, obs, ok, to);
    n_cmp++;
    if (to) begin
      n_bad++;
      $display("FAIL %s timeout: cmd_ready never rose, want 1 within 20 cycles", name);
    end else begin
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL %s op=%0d imm=%h: got en1=%b en2=%b we=%b din=%h err=%b data=%h depth=%0d, want en1=%b en2=%b we=%b din=%h err=%b data=%h depth=%0d",
                 name, op, imm, obs.en1, obs.en2, obs.we, obs.din, obs.rsp_err, obs.rsp_data, obs.depth,
                 exp.en1, exp.en2, exp.we, exp.din, exp.rsp_err, exp.rsp_data, exp.depth);
      end
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s_handshake op=%0d: got protocol/stability violation, want clean handshake", name, op);
      end
    end
  endtask

  task automatic test_push_seq();
    for (int i = 0; i < 4; i++) run_and_check("push_seq", 3'd1, 32'(i), 0);
  endtask

  task automatic test_alu();
    run_and_check("alu_add", 3'd3, '0, 0);   // 2 + 3 -> 5, depth 3
    run_and_check("alu_sub", 3'd4, '0, 1);   // 1 - 5 -> 0xFFFFFFFC, depth 2
  endtask

  task automatic test_underflow();
    apply_reset(2);
    run_and_check("uflow_pop", 3'd2, '0, 0);
    run_and_check("uflow_push", 3'd1, $urandom, 0);
    run_and_check("uflow_drop2", 3'd7, '0, 0);
  endtask

  task automatic test_overflow();
    apply_reset(2);
    for (int i = 0; i < 16; i++) run_and_check("oflow_fill", 3'd1, $urandom, 0);
    run_and_check("oflow_push17", 3'd1, 32'hDEAD_BEEF, 0);
    run_and_check("oflow_pop", 3'd2, '0, 0);
  endtask

  task automatic test_backpressure();
    run_and_check("backpressure_pop", 3'd2, '0, 5);
  endtask

  task automatic test_random();
    apply_reset(2);
    for (int i = 0; i < 80; i++) begin
      logic [2:0] op;
      op = (i % 3 == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      run_and_check("random", op, $urandom, $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_in_exec();
    bit quiet;
    apply_reset(2);
    run_and_check("rexec_push", 3'd1, 32'h1234_5678, 0);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_imm = 32'hCAFE_F00D;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (we !== 1'b1 || din !== 32'hCAFE_F00D) begin
      n_bad++;
      $display("FAIL rexec_strobe: got we=%b din=%h, want we=1 din=cafef00d", we, din);
    end
    #2 rst = 1'b0;
    ref_q.delete();
    #1;
    n_cmp++;
    if ({en1, en2, we, din, depth, rsp_valid, cmd_ready} !== '0) begin
      n_bad++;
      $display("FAIL rexec_abort: got en1=%b en2=%b we=%b din=%h depth=%0d rv=%b rdy=%b, want all 0",
               en1, en2, we, din, depth, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (4) begin @(negedge clk); quiet &= (rsp_valid === 1'b0); end
    n_cmp++;
    if (!quiet || cmd_ready !== 1'b1 || depth !== 5'd0) begin
      n_bad++;
      $display("FAIL rexec_after: got no_rsp=%b rdy=%b depth=%0d, want no_rsp=1 rdy=1 depth=0",
               quiet, cmd_ready, depth);
    end
  endtask

  initial begin
    test_reset();
    test_push_seq();
    test_alu();
    test_underflow();
    test_overflow();
    test_backpressure();
    test_random();
    test_reset_in_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stack_cmd_ctrl.md
Name: stack_cmd_ctrl

Overview:
- Command-side initiator for the stack register file (`reg_file`).
- Accepts stack-machine commands over a valid/ready handshake and sequences the file's pop/pop/push strobes (en1, en2, we, din).
- Computes binary-op results from dout1/dout2, tracks stack occupancy, and rejects underflow/overflow before any strobe is issued.
- Sits between instruction decode and reg_file in the single-cycle stack CPU.

Parameters:
- DBITS, 32, data word width; must match reg_file.
- DEPTH, 16, stack capacity in entries; must match reg_file.
- DW, $clog2(DEPTH+1), derived localparam, width of the occupancy counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  opcode: 0 NOP, 1 PUSH, 2 POP, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 DROP2.
- cmd_imm  in  DBITS  PUSH operand.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DBITS  command result.
- rsp_err  out  1  command rejected (underflow/overflow).
- en1  out  1  to reg_file: pop top.
- en2  out  1  to reg_file: pop second.
- we  out  1  to reg_file: push din.
- din  out  DBITS  to reg_file: push data.
- dout1  in  DBITS  from reg_file: top of stack (combinational).
- dout2  in  DBITS  from reg_file: second entry (combinational).
- depth  out  DW  current occupancy.

Behaviour:
- Reset (rst=0, async): state=IDLE, depth=0, cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, en1=en2=we=0, din=0. Reset mid-command aborts it with no response.
- The integration top resets reg_file in the same cycle, so the two stay consistent.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch op/imm and go to EXEC.
- EXEC (exactly 1 cycle, cmd_ready=0):
  - Legality check against registered depth: pops = 1 for POP; 2 for ADD/SUB/AND/OR/DROP2; 0 otherwise. push = 1 for PUSH/ADD/SUB/AND/OR.
  - Underflow if depth < pops. Overflow if depth - pops + push > DEPTH.
  - Legal: strobes are decoded combinationally from state==EXEC and the latched op.
    - en1 = (pops>=1), en2 = (pops==2), we = push.
    - din = imm for PUSH; otherwise the ALU result.
    - depth <= depth - pops + push at the clock edge.
    - rsp_data registered: PUSH imm; POP dout1; binary ops the ALU result; DROP2 dout1; NOP 0.
    - rsp_err <= 0.
  - Illegal: all strobes 0, din=0, depth unchanged, rsp_data <= 0, rsp_err <= 1.
  - Next state: RESP.
- ALU (operand a = dout2 = second entry, b = dout1 = top):
  - ADD a+b, SUB a-b, AND a&b, OR a|b.
  - Modulo 2^DBITS; carry/borrow discarded.
- RESP:
  - rsp_valid=1; rsp_data/rsp_err held stable until rsp_valid&rsp_ready.
  - cmd_ready=0 throughout.
  - On handshake, go to IDLE.
- Latency: command accept -> strobes in the next cycle (EXEC) -> rsp_valid the cycle after. Minimum 3 cycles per command.
- Strobes are never asserted outside EXEC.
- depth never exceeds DEPTH and never wraps below 0.
- NOP: no strobes, response data 0, err 0.
- Unknown states recover to IDLE.

Decomposition:
- stack_pkg holds:
  - opcode localparams (OP_NOP..OP_DROP2);
  - the state encodings;
  - the DBITS/DEPTH defaults shared with reg_file.
- One combinational sub-module, stack_alu: inputs op, a, b; output result DBITS. Instantiated once.

Test Plan:
- Reset: hold rst=0 for 3 cycles, then release -> all outputs 0 during reset; cmd_ready=1 and depth=0 after release.
- PUSH 0, 1, 2, 3 in sequence -> each EXEC has we=1, en1=en2=0, din=imm; rsp_data=imm, rsp_err=0; final depth=4.
- ADD with top=3, second=2 -> EXEC has en1=en2=we=1, din=5; rsp_data=5; depth=3. Then SUB with top=5, second=1 -> din=rsp_data=0xFFFFFFFC; depth=2.
- Reset, then POP at depth=0 -> rsp_err=1, rsp_data=0, no strobes, depth stays 0. DROP2 at depth=1 -> rsp_err=1, depth stays 1.
- With DEPTH=16: 16 PUSHes succeed; 17th PUSH -> rsp_err=1, we=0, depth=16. A following POP -> en1=1, rsp_data=last pushed value, depth=15.
- Backpressure: rsp_ready=0 for 5 cycles after POP -> rsp_valid=1 with rsp_data stable, cmd_ready=0. Raise rsp_ready -> IDLE the next cycle. Assert rst=0 during EXEC -> strobes drop to 0 immediately, depth=0, no response.
